// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-into-one SRAM port arbiter: source IDs and size encodings.
// The build macro SRAM_ARB_RR_EN (common macro.vh) selects round-robin arbitration in sram_arbiter.
package sram_arbiter_pkg;

  typedef logic src_id_t;

  localparam src_id_t SRC_INST = 1'b0;
  localparam src_id_t SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_fifo.sv
// In-order 1-bit FIFO holding the source ID of every accepted request until its response returns.
// DEPTH must be a power of two so the pointers wrap naturally.
module sram_arb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] slots;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slots  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = slots[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM-like port between the inst and data requesters; responses are routed in order.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over inst.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int OUTS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  src_id_t grant;
  src_id_t lock_src;
  src_id_t head;
  logic    lock_v;
  logic    gnt_req;
  logic    full;
  logic    empty;
  logic    mem_hs;
  logic    pop;
  logic    resp_err;

`ifdef SRAM_ARB_RR_EN
  src_id_t last_src;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_src <= SRC_INST;
    end else if (mem_hs) begin
      last_src <= grant;
    end
  end
`endif

  // A stalled address phase keeps its grant so the request never changes under the slave.
  always_comb begin
    grant = SRC_INST;
    if (lock_v) begin
      grant = lock_src;
`ifdef SRAM_ARB_RR_EN
    end else if (inst_req && data_req) begin
      grant = ~last_src;
`endif
    end else if (data_req) begin
      grant = SRC_DATA;
    end
  end

  always_comb begin
    if (grant == SRC_DATA) begin
      gnt_req   = data_req;
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      gnt_req   = inst_req;
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  // No full-bypass: a pop in the same cycle does not free a slot for this cycle's request.
  assign mem_req      = resetn & gnt_req & ~full;
  assign mem_hs       = mem_req & mem_addr_ok;
  assign inst_addr_ok = mem_hs & (grant == SRC_INST);
  assign data_addr_ok = mem_hs & (grant == SRC_DATA);

  assign pop          = resetn & mem_data_ok & ~empty;
  assign inst_data_ok = pop & (head == SRC_INST);
  assign data_data_ok = pop & (head == SRC_DATA);
  assign inst_rdata   = (head == SRC_INST) ? mem_rdata : '0;
  assign data_rdata   = (head == SRC_DATA) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_v   <= 1'b0;
      lock_src <= SRC_INST;
    end else if (mem_hs) begin
      lock_v   <= 1'b0;
    end else if (mem_req) begin
      lock_v   <= 1'b1;
      lock_src <= grant;
    end
  end

  // Sticky marker for a response that arrived with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_err <= 1'b0;
    end else if (mem_data_ok && empty) begin
      resp_err <= 1'b1;
    end
  end

  sram_arb_fifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (mem_hs),
    .din    (grant),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed, table-driven bench for sram_arbiter plus hand-written reset and arbitration sequences.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam logic [31:0] I_ADDR  = 32'h1c00_0000;
  localparam logic [31:0] D_ADDR  = 32'h8000_1000;
  localparam logic [31:0] I_WDATA = 32'h0000_0000;
  localparam logic [31:0] D_WDATA = 32'hcafe_f00d;

  logic        clk;
  logic        resetn;
  logic        inst_req, data_req;
  logic        inst_wr, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, data_addr;
  logic [31:0] inst_wdata, data_wdata;
  logic        inst_addr_ok, data_addr_ok;
  logic        inst_data_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTS_DEPTH(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir, dr, aok, dok;
    logic [31:0] rdata;
    logic        mreq, gnt_d, iao, dao, ido, ddo, err;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(input logic ir, dr, aok, dok, input logic [31:0] rd,
                              input logic mreq, gnt_d, iao, dao, ido, ddo, err);
    vec_t v;
    v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rdata = rd;
    v.mreq = mreq; v.gnt_d = gnt_d; v.iao = iao; v.dao = dao;
    v.ido = ido; v.ddo = ddo; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, dr, aok, dok, input logic [31:0] rd);
    inst_req = ir; data_req = dr; mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string name, input logic gnt_d);
    chk({name, "_addr"},  mem_addr,  gnt_d ? D_ADDR : I_ADDR);
    chk({name, "_wr"},    {31'b0, mem_wr}, {31'b0, gnt_d});
    chk({name, "_wdata"}, mem_wdata, gnt_d ? D_WDATA : I_WDATA);
  endtask

  initial begin
    inst_wr = 1'b0;  inst_size = SIZE_WORD; inst_wstrb = 4'h0; inst_addr = I_ADDR; inst_wdata = I_WDATA;
    data_wr = 1'b1;  data_size = SIZE_HALF; data_wstrb = 4'h3; data_addr = D_ADDR; data_wdata = D_WDATA;

    //                 ir dr aok dok rdata           mreq gd iao dao ido ddo err
    vecs[0]  = mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 32'h1234_5678,  0, 0, 0, 0, 1, 0, 0);
    vecs[3]  = mk(1, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 0);
    vecs[4]  = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 32'haaaa_0001,  0, 0, 0, 0, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 1, 32'hbbbb_0002,  0, 0, 0, 0, 1, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 1, 0, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 0);
    vecs[11] = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 32'h0000_d00d,  0, 0, 0, 0, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 1, 32'h1111_2222,  0, 0, 0, 0, 1, 0, 0);
    vecs[14] = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
    vecs[15] = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 0);
    vecs[17] = mk(0, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 0);
    vecs[18] = mk(1, 0, 1, 1, 32'h3333_3333,  0, 0, 0, 0, 1, 0, 0);
    vecs[19] = mk(1, 0, 1, 0, 32'h0,          1, 0, 1, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 1, 32'h4444_4444,  0, 0, 0, 0, 1, 0, 0);
    vecs[21] = mk(0, 0, 0, 1, 32'h5555_5555,  0, 0, 0, 0, 0, 1, 0);
    vecs[22] = mk(0, 0, 0, 1, 32'h6666_6666,  0, 0, 0, 0, 0, 1, 0);
    vecs[23] = mk(0, 0, 0, 1, 32'h7777_7777,  0, 0, 0, 0, 1, 0, 0);
    vecs[24] = mk(0, 0, 0, 1, 32'h8888_8888,  0, 0, 0, 0, 0, 0, 0);
    vecs[25] = mk(0, 1, 1, 0, 32'h0,          1, 1, 0, 1, 0, 0, 1);
    vecs[26] = mk(1, 0, 1, 1, 32'h9999_9999,  1, 0, 1, 0, 0, 1, 1);
    vecs[27] = mk(0, 0, 0, 1, 32'habcd_ef01,  0, 0, 0, 0, 1, 0, 1);

    // Reset asserted with every handshake input high: all outputs must stay quiet.
    resetn = 1'b0;
    drive(1, 1, 1, 1, 32'hdead_beef);
    #3;
    chk("rst_mem_req",      {31'b0, mem_req},      32'd0);
    chk("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
    chk("rst_inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
    chk("rst_data_data_ok", {31'b0, data_data_ok}, 32'd0);
    chk("rst_resp_err",     {31'b0, dut.resp_err}, 32'd0);
    @(posedge clk);
    next_cycle();
    resetn = 1'b1;

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].ir, vecs[i].dr, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
      #4;
      chk($sformatf("v%0d_mem_req", i),      {31'b0, mem_req},      {31'b0, vecs[i].mreq});
      chk($sformatf("v%0d_inst_addr_ok", i), {31'b0, inst_addr_ok}, {31'b0, vecs[i].iao});
      chk($sformatf("v%0d_data_addr_ok", i), {31'b0, data_addr_ok}, {31'b0, vecs[i].dao});
      chk($sformatf("v%0d_inst_data_ok", i), {31'b0, inst_data_ok}, {31'b0, vecs[i].ido});
      chk($sformatf("v%0d_data_data_ok", i), {31'b0, data_data_ok}, {31'b0, vecs[i].ddo});
      chk($sformatf("v%0d_resp_err", i),     {31'b0, dut.resp_err}, {31'b0, vecs[i].err});
      if (vecs[i].mreq) chk_grant($sformatf("v%0d", i), vecs[i].gnt_d);
      if (vecs[i].ido)  chk($sformatf("v%0d_inst_rdata", i), inst_rdata, vecs[i].rdata);
      if (vecs[i].ddo)  chk($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].rdata);
      next_cycle();
    end

    // Reset with two requests outstanding, then a stray response.
    drive(1, 0, 1, 0, 32'h0);
    #4 chk("rmf_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
    next_cycle();
    drive(0, 1, 1, 0, 32'h0);
    #4 chk("rmf_data_addr_ok", {31'b0, data_addr_ok}, 32'd1);
    next_cycle();
    drive(1, 1, 1, 1, 32'h5a5a_5a5a);
    resetn = 1'b0;
    #4;
    chk("rmf_mem_req",      {31'b0, mem_req},      32'd0);
    chk("rmf_addr_ok",      {30'b0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("rmf_data_ok",      {30'b0, inst_data_ok, data_data_ok}, 32'd0);
    chk("rmf_err_cleared",  {31'b0, dut.resp_err}, 32'd0);
    next_cycle();
    resetn = 1'b1;
    drive(0, 0, 0, 1, 32'h6b6b_6b6b);
    #4;
    chk("stray_inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
    chk("stray_data_data_ok", {31'b0, data_data_ok}, 32'd0);
    next_cycle();
    drive(0, 0, 0, 0, 32'h0);
    #4 chk("stray_resp_err", {31'b0, dut.resp_err}, 32'd1);
    next_cycle();

    // Continuous conflict after reset: round-robin alternates, fixed priority keeps data.
    resetn = 1'b0;
    #2 resetn = 1'b1;
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
`ifdef SRAM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      drive(1, 1, 1, 0, 32'h0);
      #4;
      chk($sformatf("arb%0d_mem_req", k),      {31'b0, mem_req},      32'd1);
      chk($sformatf("arb%0d_data_addr_ok", k), {31'b0, data_addr_ok}, {31'b0, exp_d});
      chk($sformatf("arb%0d_inst_addr_ok", k), {31'b0, inst_addr_ok}, {31'b0, ~exp_d});
      chk_grant($sformatf("arb%0d", k), exp_d);
      next_cycle();
    end
    drive(0, 0, 0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
